// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS-subset main control FSM with memory wait watchdog
module mc_main_control #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       alu_op,
  output logic [2:0] alu_sel_direct,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_READ = 4'd4,
    MEM_WB = 4'd5, MEM_WRITE = 4'd6, R_EXEC = 4'd7, R_WB = 4'd8, BRANCH = 4'd9,
    JUMP = 4'd10, ADDI_EXEC = 4'd11, ADDI_WB = 4'd12, HALT = 4'd13
  } state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, stalled, fault;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    stalled = (state_q == FETCH || state_q == MEM_READ || state_q == MEM_WRITE) && !mem_ready;
    fault = stalled && cnt_q == CNT_W'(WAIT_LIMIT - 1);
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = FETCH;
      FETCH:     state_d = mem_ready ? DECODE : FETCH;
      DECODE:
        case (opcode)
          6'b000000:            state_d = R_EXEC;
          6'b100011, 6'b101011: state_d = MEM_ADDR;
          6'b000100:            state_d = BRANCH;
          6'b000010:            state_d = JUMP;
          6'b001000:            state_d = ADDI_EXEC;
          default:              state_d = FETCH;
        endcase
      MEM_ADDR:  state_d = opcode == 6'b100011 ? MEM_READ : MEM_WRITE;
      MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:    state_d = R_WB;
      ADDI_EXEC: state_d = ADDI_WB;
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = IDLE;
    endcase
    if (fault) state_d = HALT;
    cnt_d = (stalled && state_d == state_q) ? cnt_q + 1'b1 : '0;
    err_d = err_q | fault;
  end
  always_comb begin
    alu_op = 1'b0;
    alu_sel_direct = 3'b010;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    pc_source = 2'b00;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        illegal_op = !(opcode inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
      end
      MEM_ADDR, ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d = 1'b1;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d = 1'b1;
        instr_done = mem_ready;
      end
      R_EXEC: begin
        alu_op = 1'b1;
        alu_src_a = 1'b1;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        pc_write_cond = 1'b1;
        alu_src_a = 1'b1;
        alu_sel_direct = 3'b110;
        pc_source = 2'b01;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_source = 2'b10;
        instr_done = 1'b1;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end
  assign mem_err = err_q;
  assign state = state_q;
endmodule
